// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO divide sequencer: FSM states and ALU divider opcodes.
package hilo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        WAIT  = 2'd2
    } div_state_e;

    localparam logic [3:0] ALU_DIV  = 4'b1100;
    localparam logic [3:0] ALU_DIVU = 4'b1101;
    localparam logic [3:0] ALU_NOP  = 4'b0000;

    function automatic logic [3:0] div_opcode(input logic is_signed);
        return is_signed ? ALU_DIV : ALU_DIVU;
    endfunction

endpackage

// File: rtl/hilo_regs.sv
// Architectural HI/LO register pair. With HILO_BYPASS_EN defined, an accepted
// mthi/mtlo write is visible on hi/lo in the same cycle.
module hilo_regs #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hi_we,
    input  logic [WIDTH-1:0] hi_d,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] lo_d,
`ifdef HILO_BYPASS_EN
    input  logic             hi_byp,
    input  logic             lo_byp,
    input  logic [WIDTH-1:0] byp_d,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (hi_we) hi_q <= hi_d;
            if (lo_we) lo_q <= lo_d;
        end
    end

`ifdef HILO_BYPASS_EN
    assign hi = hi_byp ? byp_d : hi_q;
    assign lo = lo_byp ? byp_d : lo_q;
`else
    assign hi = hi_q;
    assign lo = lo_q;
`endif

endmodule

// File: rtl/hilo_div_seq.sv
// Sequences a multi-cycle ALU divide into HI/LO with a timeout watchdog.
// Optional macro HILO_BYPASS_EN forwards accepted mthi/mtlo data combinationally.
module hilo_div_seq
    import hilo_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    output logic [3:0]       div_ctrl,
    output logic             divrst,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             err
);

    localparam int              CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    div_state_e       state;
    div_state_e       state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout;

    logic             idle;
    logic             div_go;
    logic             zero_go;
    logic             capture;
    logic             mthi_acc;
    logic             mtlo_acc;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;

    assign idle     = (state == IDLE);
    assign div_go   = idle && start && (op_b != '0);
    assign zero_go  = idle && start && (op_b == '0);
    assign capture  = (state == WAIT) && div_done;
    assign mthi_acc = idle && !start && mthi;
    assign mtlo_acc = idle && !start && mtlo;

    assign divrst = (state == PULSE);
    assign busy   = !idle;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        timeout   = 1'b0;
        case (state)
            IDLE:  if (div_go) state_nxt = PULSE;
            PULSE: state_nxt = WAIT;
            WAIT: begin
                if (div_done) begin
                    state_nxt = IDLE;
                end else if (wait_cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    timeout   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, opcode, watchdog counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_a    <= '0;
            div_b    <= '0;
            div_ctrl <= ALU_NOP;
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (div_go) begin
                div_a    <= op_a;
                div_b    <= op_b;
                div_ctrl <= div_opcode(sign);
            end else if (state != IDLE && state_nxt == IDLE) begin
                div_ctrl <= ALU_NOP;
            end
            if (state == WAIT && state_nxt == WAIT) wait_cnt <= wait_cnt + 1'b1;
            else                                    wait_cnt <= '0;
            if (timeout) err <= 1'b1;
        end
    end

    // Divide-by-zero result wins over a completed divide, which wins over mthi/mtlo
    always_comb begin
        hi_we = zero_go || capture || mthi_acc;
        lo_we = zero_go || capture || mtlo_acc;
        hi_d  = wdata;
        lo_d  = wdata;
        if (zero_go) begin
            hi_d = op_a;
            lo_d = '1;
        end else if (capture) begin
            hi_d = div_r;
            lo_d = div_q;
        end
    end

    hilo_regs #(
        .WIDTH (WIDTH)
    ) u_regs (
        .clk    (clk),
        .rst    (rst),
        .hi_we  (hi_we),
        .hi_d   (hi_d),
        .lo_we  (lo_we),
        .lo_d   (lo_d),
`ifdef HILO_BYPASS_EN
        .hi_byp (mthi_acc),
        .lo_byp (mtlo_acc),
        .byp_d  (wdata),
`endif
        .hi     (hi),
        .lo     (lo)
    );

endmodule

// File: tb/tb_hilo_div_seq.sv
// Randomized bench for hilo_div_seq; the bench plays the ALU divider and tracks HI/LO/err.
module tb_hilo_div_seq;

    localparam int WIDTH    = 32;
    localparam int MAX_WAIT = 40;

    logic             clk = 1'b0;
    logic             rst;
    logic             start, sign, mthi, mtlo, div_done;
    logic [WIDTH-1:0] op_a, op_b, wdata, div_q, div_r;
    logic [WIDTH-1:0] div_a, div_b, hi, lo;
    logic [3:0]       div_ctrl;
    logic             divrst, busy, err;

    int               n_chk = 0;
    int               n_err = 0;
    logic [WIDTH-1:0] hi_m, lo_m;
    logic             err_m;

    always #5 clk = ~clk;

    hilo_div_seq #(
        .WIDTH    (WIDTH),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sign     (sign),
        .op_a     (op_a),
        .op_b     (op_b),
        .mthi     (mthi),
        .mtlo     (mtlo),
        .wdata    (wdata),
        .div_a    (div_a),
        .div_b    (div_b),
        .div_ctrl (div_ctrl),
        .divrst   (divrst),
        .div_done (div_done),
        .div_q    (div_q),
        .div_r    (div_r),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .err      (err)
    );

    task automatic chk_val(input string tag, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_q(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        if (s) return $signed(a) / $signed(b);
        return a / b;
    endfunction

    function automatic logic [WIDTH-1:0] ref_r(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        if (s) return $signed(a) % $signed(b);
        return a % b;
    endfunction

    task automatic idle_inputs();
        start = 0; mthi = 0; mtlo = 0; div_done = 0;
    endtask

    // dly = WAIT cycle in which the divider reports done; beyond MAX_WAIT means never
    task automatic run_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                           input int dly, input bit noise);
        bit               to;
        int               wait_cyc, busy_cnt, rst_cnt;
        logic [WIDTH-1:0] q, r;
        to       = (dly > MAX_WAIT);
        wait_cyc = to ? MAX_WAIT : dly;
        q        = ref_q(a, b, s);
        r        = ref_r(a, b, s);
        @(negedge clk);
        start = 1; sign = s; op_a = a; op_b = b;
        mthi = noise; mtlo = noise; wdata = $urandom;
        @(negedge clk);
        idle_inputs();
        op_a = $urandom; op_b = $urandom | 1; sign = ~s;
        chk_val("divrst_pulse", {31'd0, divrst}, 1);
        chk_val("div_a_latch", div_a, a);
        chk_val("div_b_latch", div_b, b);
        chk_val("div_ctrl", {28'd0, div_ctrl}, {28'd0, s ? 4'b1100 : 4'b1101});
        busy_cnt = int'(busy);
        rst_cnt  = int'(divrst);
        for (int k = 1; k <= wait_cyc; k++) begin
            @(negedge clk);
            idle_inputs();
            busy_cnt += int'(busy);
            rst_cnt  += int'(divrst);
            if (k == wait_cyc) chk_val("div_a_hold", div_a, a);
            if (noise) begin
                mthi  = (k == 1) ? 1'b1 : 1'($urandom);
                mtlo  = 1'($urandom);
                wdata = (k == 1) ? 32'hA5A5_A5A5 : $urandom;
                start = 1'($urandom);
                op_a  = $urandom;
                op_b  = $urandom | 1;
            end
            if (!to && k == wait_cyc) begin
                div_done = 1; div_q = q; div_r = r;
            end
        end
        @(negedge clk);
        idle_inputs();
        if (to) err_m = 1;
        else begin
            hi_m = r;
            lo_m = q;
        end
        chk_val("busy_after", {31'd0, busy}, 0);
        chk_val("busy_cycles", busy_cnt, 1 + wait_cyc);
        chk_val("divrst_cycles", rst_cnt, 1);
        chk_val("div_ctrl_idle", {28'd0, div_ctrl}, 0);
        chk_val("hi_div", hi, hi_m);
        chk_val("lo_div", lo, lo_m);
        chk_val("err", {31'd0, err}, {31'd0, err_m});
    endtask

    task automatic zero_div(input logic [WIDTH-1:0] a, input bit with_mt);
        @(negedge clk);
        start = 1; op_a = a; op_b = 0; sign = 1'($urandom);
        mthi = with_mt; mtlo = with_mt; wdata = $urandom;
        @(negedge clk);
        idle_inputs();
        hi_m = a;
        lo_m = '1;
        chk_val("zdiv_busy", {31'd0, busy}, 0);
        chk_val("zdiv_divrst", {31'd0, divrst}, 0);
        chk_val("zdiv_hi", hi, hi_m);
        chk_val("zdiv_lo", lo, lo_m);
        @(negedge clk);
        chk_val("zdiv_divrst2", {31'd0, divrst}, 0);
    endtask

    task automatic mt_write(input bit wh, input bit wl, input logic [WIDTH-1:0] d);
        @(negedge clk);
        mthi = wh; mtlo = wl; wdata = d;
        #1;
`ifdef HILO_BYPASS_EN
        chk_val("mt_hi_same", hi, wh ? d : hi_m);
        chk_val("mt_lo_same", lo, wl ? d : lo_m);
`else
        chk_val("mt_hi_same", hi, hi_m);
        chk_val("mt_lo_same", lo, lo_m);
`endif
        @(negedge clk);
        idle_inputs();
        if (wh) hi_m = d;
        if (wl) lo_m = d;
        chk_val("mt_hi", hi, hi_m);
        chk_val("mt_lo", lo, lo_m);
    endtask

    task automatic idle_done();
        @(negedge clk);
        div_done = 1; div_q = $urandom; div_r = $urandom;
        @(negedge clk);
        idle_inputs();
        chk_val("idle_done_hi", hi, hi_m);
        chk_val("idle_done_lo", lo, lo_m);
        chk_val("idle_done_busy", {31'd0, busy}, 0);
    endtask

    task automatic reset_in_wait();
        @(negedge clk);
        start = 1; op_a = 32'd100; op_b = 32'd7; sign = 0;
        @(negedge clk);
        idle_inputs();
        repeat (10) @(negedge clk);
        #2 rst = 0;
        #1;
        hi_m = 0; lo_m = 0; err_m = 0;
        chk_val("rst_hi", hi, 0);
        chk_val("rst_lo", lo, 0);
        chk_val("rst_busy", {31'd0, busy}, 0);
        chk_val("rst_divrst", {31'd0, divrst}, 0);
        chk_val("rst_div_a", div_a, 0);
        chk_val("rst_ctrl", {28'd0, div_ctrl}, 0);
        @(negedge clk);
        rst = 1;
        repeat (3) @(negedge clk);
        div_done = 1; div_q = 32'd14; div_r = 32'd2;
        @(negedge clk);
        idle_inputs();
        chk_val("post_rst_hi", hi, 0);
        chk_val("post_rst_lo", lo, 0);
        chk_val("post_rst_busy", {31'd0, busy}, 0);
        chk_val("post_rst_err", {31'd0, err}, 0);
    endtask

    initial begin
        rst = 0;
        idle_inputs();
        sign = 0; op_a = 0; op_b = 0; wdata = 0; div_q = 0; div_r = 0;
        hi_m = 0; lo_m = 0; err_m = 0;
        #12;
        chk_val("reset_hi", hi, 0);
        chk_val("reset_lo", lo, 0);
        chk_val("reset_busy", {31'd0, busy}, 0);
        chk_val("reset_err", {31'd0, err}, 0);
        chk_val("reset_divrst", {31'd0, divrst}, 0);
        chk_val("reset_ctrl", {28'd0, div_ctrl}, 0);
        @(negedge clk);
        rst = 1;

        run_div(32'd5, 32'd2, 1'b1, 34, 1'b0);
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 6, 1'b0);
        zero_div(32'd7, 1'b0);
        run_div(32'd1000, 32'd33, 1'b0, 12, 1'b1);
        mt_write(1'b1, 1'b0, 32'hA5A5_A5A5);
        mt_write(1'b0, 1'b1, 32'h1234_5678);
        run_div(32'd9, 32'd4, 1'b0, MAX_WAIT, 1'b0);
        run_div(32'd77, 32'd5, 1'b0, MAX_WAIT + 1, 1'b0);
        idle_done();
        zero_div(32'hDEAD_BEEF, 1'b1);
        reset_in_wait();

        for (int i = 0; i < 30; i++) begin
            logic [WIDTH-1:0] a, b;
            logic             s;
            a = $urandom;
            b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 300)) : $urandom;
            if (b == 0) b = 1;
            s = 1'($urandom);
            if (s && a == 32'h8000_0000 && b == '1) b = 2;
            case ($urandom_range(0, 5))
                0, 1, 2: run_div(a, b, s, $urandom_range(1, MAX_WAIT + 2), 1'($urandom));
                3:       zero_div(a, 1'($urandom));
                4:       mt_write(1'($urandom), 1'($urandom), $urandom);
                default: idle_done();
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/hilo_div_seq.md
HILO_DIV_SEQ -- requirements
Module: hilo_div_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width.
REQ-002 SHALL have parameter: MAX_WAIT, 40, cycles allowed between divider reset release and div_done.
REQ-003 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port: rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: start  in  1  issue divide from execute stage.
REQ-006 SHALL have port: sign  in  1  1=DIV (signed), 0=DIVU.
REQ-007 SHALL have port: op_a / op_b  in  WIDTH  dividend / divisor.
REQ-008 SHALL have port: mthi / mtlo / wdata  in  1/1/WIDTH  HI/LO write from pipeline.
REQ-009 SHALL have port: div_a / div_b / div_ctrl / divrst  out  WIDTH/WIDTH/4/1  drive to ALU divider.
REQ-010 SHALL have port: div_done / div_q / div_r  in  1/WIDTH/WIDTH  divider completion, quotient, remainder.
REQ-011 SHALL have port: hi / lo  out  WIDTH  architectural HI/LO.
REQ-012 SHALL have port: busy / err  out  1/1  pipeline stall; sticky timeout flag.

Function
REQ-013 SHALL implement states IDLE, PULSE, WAIT; IDLE->PULSE on start with op_b!=0; PULSE->WAIT after exactly one cycle; WAIT->IDLE on div_done or wait counter = MAX_WAIT.
REQ-014 SHALL latch op_a, op_b, sign into div_a, div_b, div_ctrl on the start edge; they stay constant until return to IDLE.
REQ-015 SHALL drive div_ctrl = 4'b1100 when sign=1, 4'b1101 when sign=0; 4'b0000 in IDLE.
REQ-016 SHALL assert divrst high for exactly the PULSE cycle only.
REQ-017 SHALL assert busy from the cycle after start until the cycle HI/LO capture occurs, inclusive of PULSE and WAIT.
REQ-018 SHALL on div_done in WAIT write lo<=div_q, hi<=div_r at that edge; busy deasserts the next cycle.
REQ-019 SHALL on start with op_b==0 stay IDLE, write lo<={WIDTH{1'b1}}, hi<=op_a next edge, never pulse divrst.
REQ-020 SHALL on wait counter reaching MAX_WAIT return to IDLE, leave hi/lo unchanged, set err until reset.
REQ-021 SHALL ignore start while busy; no re-latch of operands.
REQ-022 SHALL ignore mthi/mtlo while busy; in IDLE write wdata to hi/lo next edge.
REQ-023 SHALL give start priority over mthi/mtlo in the same IDLE cycle; divide result overwrites both.
REQ-024 SHALL ignore div_done outside WAIT.

Reset
REQ-025 SHALL on rst low immediately force IDLE, hi=0, lo=0, busy=0, err=0, divrst=0, div_ctrl=0, div_a=0, div_b=0, counter=0.
REQ-026 SHALL abandon any in-flight divide on reset; a div_done after release is ignored.

Configuration
REQ-027 SHALL support macro HILO_BYPASS_EN: defined -> hi/lo outputs show wdata combinationally in a cycle with accepted mthi/mtlo; undefined -> hi/lo change only after the edge.

Structure
REQ-028 SHALL place state enum, ALU_DIV=4'b1100, ALU_DIVU=4'b1101 in shared package hilo_pkg.
REQ-029 SHALL isolate HI/LO register pair plus bypass in one sub-module hilo_regs.

Verification
REQ-030 SHALL cover: op_a=5, op_b=2, sign=1, model done after 33 cycles q=2 r=1 -> divrst one cycle, lo=2, hi=1, busy 35 cycles.
REQ-031 SHALL cover: op_a=32'hFFFFFFF9, op_b=2, sign=1 -> div_ctrl=4'b1100, lo=32'hFFFFFFFD, hi=32'hFFFFFFFF from model.
REQ-032 SHALL cover: op_b=0, op_a=7 -> no divrst, busy=0, lo=32'hFFFFFFFF, hi=7 next cycle.
REQ-033 SHALL cover: mthi wdata=32'hA5A5A5A5 during WAIT -> hi unchanged; same in IDLE -> hi=32'hA5A5A5A5.
REQ-034 SHALL cover: div_done withheld -> err=1, busy=0 after MAX_WAIT, hi/lo unchanged.
REQ-035 SHALL cover: rst low in WAIT cycle 10 -> hi=lo=0, busy=0 immediately; later div_done ignored.
